sma_window_engine: RTL and testbench

Per-stock simple-moving-average engine and successor to the fixed 4-stock price buffer controller. It owns a circular sample RAM of WINDOW entries per stock and per-stock write pointers, fill counts and running sums. It accepts one price per handshake and emits the updated SMA for that stock. It sits between the feed/order-book price output and the strategy logic.

---
 rtl/sma_pkg.sv | 26 ++
 rtl/sma_sample_ram.sv | 22 ++
 rtl/sma_window_engine.sv | 144 ++++++++++++++
 tb/tb_sma_window_engine.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sma_pkg.sv
// sma_pkg: shared types and width helpers for the moving-average engine
package sma_pkg;

    localparam int DEF_NUM_STOCKS = 4;

    typedef logic [$clog2(DEF_NUM_STOCKS)-1:0] stock_id_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_UPDATE
    } state_t;

    function automatic int id_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int sum_w(int pw, int win);
        return pw + $clog2(win);
    endfunction

    function automatic int addr_w(int win, int n);
        return (win * n > 1) ? $clog2(win * n) : 1;
    endfunction

endpackage

// File: rtl/sma_sample_ram.sv
// sma_sample_ram: single-port sample store with registered read, no reset
module sma_sample_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 32
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] mem [DEPTH];

    // read-before-write: the read returns the old sample at a written address
    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_addr] <= i_wdata;
        o_rdata <= mem[i_addr];
    end

endmodule

// File: rtl/sma_window_engine.sv
// sma_window_engine: per-stock circular window with running sum and SMA output
module sma_window_engine
    import sma_pkg::*;
#(
    parameter  int WINDOW      = 64,
    parameter  int NUM_STOCKS  = 4,
    parameter  int PRICE_WIDTH = 32,
    localparam int STOCK_ID_W  = id_w(NUM_STOCKS),
    localparam int SUM_W       = sum_w(PRICE_WIDTH, WINDOW),
    localparam int PTR_W       = $clog2(WINDOW),
    localparam int CNT_W       = PTR_W + 1,
    localparam int ADDR_W      = addr_w(WINDOW, NUM_STOCKS)
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_price_valid,
    output logic                   o_price_ready,
    input  logic [STOCK_ID_W-1:0]  i_stock_id,
    input  logic [PRICE_WIDTH-1:0] i_price,
    input  logic                   i_flush,
    input  logic [STOCK_ID_W-1:0]  i_flush_stock_id,
    output logic                   o_sma_valid,
    output logic [STOCK_ID_W-1:0]  o_sma_stock_id,
    output logic [PRICE_WIDTH-1:0] o_sma,
    output logic                   o_sma_full,
    output logic [CNT_W-1:0]       o_sample_count
);

    state_t state, next_state;

    logic [PTR_W-1:0]       ptr [NUM_STOCKS];
    logic [CNT_W-1:0]       cnt [NUM_STOCKS];
    logic [SUM_W-1:0]       sum [NUM_STOCKS];

    logic [STOCK_ID_W-1:0]  cur_stock, in_idx;
    logic [PRICE_WIDTH-1:0] cur_price, old_sample, evicted;
    logic [ADDR_W-1:0]      cur_addr, acc_addr, ram_addr;
    logic [SUM_W-1:0]       new_sum;
    logic [CNT_W-1:0]       cur_cnt, new_cnt;
    logic                   cur_ok, in_ok, flush_ok, accept, ram_we, cur_full;

    // out-of-range ids are folded onto stock 0 for indexing and then suppressed
    always_comb begin
        in_ok    = 32'(i_stock_id) < NUM_STOCKS;
        in_idx   = in_ok ? i_stock_id : '0;
        acc_addr = ADDR_W'(32'(in_idx) * WINDOW + 32'(ptr[in_idx]));
        flush_ok = i_flush && (32'(i_flush_stock_id) < NUM_STOCKS);
    end

    // state register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= next_state;
    end

    // next-state: fixed three-cycle walk once a sample is taken
    always_comb begin
        next_state = (state == S_IDLE) ? (accept ? S_READ : S_IDLE) :
                     (state == S_READ) ? S_UPDATE : S_IDLE;
    end

    // handshake and RAM control; flush wins over a simultaneous price
    always_comb begin
        o_price_ready = (state == S_IDLE) && !i_flush;
        accept        = i_price_valid && o_price_ready;
        ram_we        = (state == S_UPDATE) && cur_ok;
        ram_addr      = (state == S_IDLE) ? acc_addr : cur_addr;
    end

    // new window statistics; eviction only once the window has wrapped
    always_comb begin
        cur_cnt  = cnt[cur_stock];
        cur_full = cur_cnt == CNT_W'(WINDOW);
        evicted  = cur_full ? old_sample : '0;
        new_sum  = sum[cur_stock] - SUM_W'(evicted) + SUM_W'(cur_price);
        new_cnt  = cur_full ? cur_cnt : cur_cnt + 1'b1;
    end

    // capture the accepted sample for the read/update cycles
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cur_stock <= '0;
            cur_price <= '0;
            cur_ok    <= 1'b0;
            cur_addr  <= '0;
        end else if (accept) begin
            cur_stock <= in_idx;
            cur_price <= i_price;
            cur_ok    <= in_ok;
            cur_addr  <= acc_addr;
        end
    end

    // per-stock pointer, fill count and running sum
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_STOCKS; k++) begin
                ptr[k] <= '0;
                cnt[k] <= '0;
                sum[k] <= '0;
            end
        end else if (state == S_IDLE && flush_ok) begin
            ptr[i_flush_stock_id] <= '0;
            cnt[i_flush_stock_id] <= '0;
            sum[i_flush_stock_id] <= '0;
        end else if (ram_we) begin
            ptr[cur_stock] <= ptr[cur_stock] + 1'b1;
            cnt[cur_stock] <= new_cnt;
            sum[cur_stock] <= new_sum;
        end
    end

    // result registers hold until the next update
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sma_valid    <= 1'b0;
            o_sma_stock_id <= '0;
            o_sma          <= '0;
            o_sma_full     <= 1'b0;
            o_sample_count <= '0;
        end else begin
            o_sma_valid <= ram_we;
            if (ram_we) begin
                o_sma_stock_id <= cur_stock;
                o_sma          <= PRICE_WIDTH'(new_sum >> PTR_W);
                o_sma_full     <= new_cnt == CNT_W'(WINDOW);
                o_sample_count <= new_cnt;
            end
        end
    end

    sma_sample_ram #(
        .DEPTH(WINDOW * NUM_STOCKS),
        .AW   (ADDR_W),
        .DW   (PRICE_WIDTH)
    ) u_ram (
        .i_clk  (i_clk),
        .i_we   (ram_we),
        .i_addr (ram_addr),
        .i_wdata(cur_price),
        .o_rdata(old_sample)
    );

endmodule

// File: tb/tb_sma_window_engine.sv
// tb_sma_window_engine: randomized scoreboard bench with a window-queue reference model
module tb_sma_window_engine;
    import sma_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_price_valid = 1'b0;
    logic        o_price_ready;
    stock_id_t   i_stock_id = '0;
    logic [31:0] i_price = '0;
    logic        i_flush = 1'b0;
    stock_id_t   i_flush_stock_id = '0;
    logic        o_sma_valid;
    logic [1:0]  o_sma_stock_id;
    logic [31:0] o_sma;
    logic        o_sma_full;
    logic [2:0]  o_sample_count;

    sma_window_engine #(.WINDOW(4), .NUM_STOCKS(4), .PRICE_WIDTH(32)) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_price_valid   (i_price_valid),
        .o_price_ready   (o_price_ready),
        .i_stock_id      (i_stock_id),
        .i_price         (i_price),
        .i_flush         (i_flush),
        .i_flush_stock_id(i_flush_stock_id),
        .o_sma_valid     (o_sma_valid),
        .o_sma_stock_id  (o_sma_stock_id),
        .o_sma           (o_sma),
        .o_sma_full      (o_sma_full),
        .o_sample_count  (o_sample_count)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int          stock;
        logic [31:0] sma;
        int          cnt;
        bit          full;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] hist[4][$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_acc = 0;

    always @(posedge i_clk) cyc++;

    // reference: the window is literally the last four prices of the stock
    function automatic void model_push(int s, logic [31:0] p, int c);
        exp_t   e;
        longint t = 0;
        hist[s].push_back(p);
        if (hist[s].size() > 4) void'(hist[s].pop_front());
        for (int k = 0; k < hist[s].size(); k++) t += longint'(hist[s][k]);
        e.stock = s;
        e.sma   = 32'(t / 4);
        e.cnt   = hist[s].size();
        e.full  = (e.cnt == 4);
        e.cyc   = c;
        sbq.push_back(e);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // monitor: every presented result must match the oldest expectation
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_reset && o_sma_valid) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got stock=%0d sma=%0h at cycle %0d, required no result",
                         o_sma_stock_id, o_sma, cyc);
            end else begin
                e = sbq.pop_front();
                if (32'(o_sma_stock_id) != e.stock || o_sma !== e.sma || 32'(o_sample_count) != e.cnt ||
                    o_sma_full !== e.full || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL result: got stock=%0d sma=%0h cnt=%0d full=%0d cyc=%0d, required stock=%0d sma=%0h cnt=%0d full=%0d cyc=%0d",
                             o_sma_stock_id, o_sma, o_sample_count, o_sma_full, cyc,
                             e.stock, e.sma, e.cnt, e.full, e.cyc);
                end
            end
        end
    end

    task automatic send(input int s, input logic [31:0] p, input bit rec, input bit keep);
        int n = 0;
        @(negedge i_clk);
        i_price_valid = 1'b1;
        i_stock_id    = stock_id_t'(s);
        i_price       = p;
        #1;
        while (!o_price_ready && n < 20) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (!o_price_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got ready=0 after %0d cycles, required ready=1", n);
            i_price_valid = 1'b0;
            return;
        end
        last_acc = cyc;
        if (rec) model_push(s, p, cyc + 3);
        @(posedge i_clk);
        #1;
        if (!keep) i_price_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic flush(input int s);
        @(negedge i_clk);
        i_flush          = 1'b1;
        i_flush_stock_id = stock_id_t'(s);
        @(posedge i_clk);
        #1;
        i_flush = 1'b0;
        hist[s].delete();
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) hist[k].delete();
    endtask

    initial begin
        int prev;
        int s;
        logic [31:0] p;
        repeat (3) @(negedge i_clk);
        check("reset_valid", o_sma_valid, 0);
        check("reset_count", o_sample_count, 0);
        i_reset = 1'b0;
        #1;
        check("ready_after_reset", o_price_ready, 1);
        // fill and slide on stock 0
        send(0, 10, 1, 0);
        send(0, 20, 1, 0);
        send(0, 30, 1, 0);
        send(0, 40, 1, 0);
        send(0, 50, 1, 0);
        send(1, 100, 1, 0);
        drain();
        // flush stock 0 and confirm stock 1 keeps its window
        flush(0);
        send(0, 8, 1, 0);
        send(1, 100, 1, 0);
        drain();
        // interleaved channels
        flush(0);
        flush(1);
        send(0, 10, 1, 0);
        send(1, 100, 1, 0);
        send(0, 20, 1, 0);
        // full-scale prices must not wrap the sum
        for (int k = 0; k < 5; k++) send(2, 32'hFFFF_FFFF, 1, 0);
        drain();
        // flush together with a price: not taken until flush drops
        @(negedge i_clk);
        i_flush = 1'b1;
        i_flush_stock_id = 2'd3;
        i_price_valid = 1'b1;
        i_stock_id = 2'd3;
        i_price = 77;
        #1;
        check("ready_low_on_flush", o_price_ready, 0);
        @(negedge i_clk);
        i_flush = 1'b0;
        hist[3].delete();
        #1;
        check("ready_after_flush", o_price_ready, 1);
        model_push(3, 77, cyc + 3);
        @(posedge i_clk);
        #1;
        i_price_valid = 1'b0;
        drain();
        // continuous valid: one acceptance every three cycles
        send(1, $urandom_range(0, 5000), 1, 1);
        prev = last_acc;
        for (int k = 0; k < 5; k++) begin
            send(1, $urandom_range(0, 5000), 1, 1);
            check("accept_spacing", last_acc - prev, 3);
            prev = last_acc;
        end
        i_price_valid = 1'b0;
        drain();
        // mid-run reset clears everything
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check("midreset_valid", o_sma_valid, 0);
        check("midreset_sma", o_sma, 0);
        check("midreset_count", o_sample_count, 0);
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        check("midreset_ready", o_price_ready, 1);
        clear_model();
        // reset while the engine is in its read cycle aborts the sample
        send(0, 55, 1, 0);
        send(0, 66, 0, 0);
        i_reset = 1'b1;
        sbq.delete();
        clear_model();
        @(negedge i_clk);
        i_reset = 1'b0;
        repeat (5) @(negedge i_clk);
        send(0, 40, 1, 0);
        drain();
        // randomized traffic with occasional flushes
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) begin
                drain();
                flush($urandom_range(0, 3));
            end
            s = $urandom_range(0, 3);
            p = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 100) : $urandom_range(0, 1000);
            send(s, p, 1, 0);
        end
        drain();
        repeat (3) @(negedge i_clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, required completion", $time);
        $fatal(1);
    end

endmodule
